// File: rtl/pdm_pkg.sv
// Shared sizing helpers for the PDM CIC decimator: accumulator width,
// CIC DC gain, signed saturation limits and per-channel bus slicing.
package pdm_pkg;

   function automatic int unsigned acc_width(input int unsigned order, input int unsigned decim);
      return order * $clog2(decim) + 1;
   endfunction

   // DECIM^CIC_ORDER, the response of the filter to a constant unit input
   function automatic longint cic_gain(input int unsigned order, input int unsigned decim);
      longint g;
      g = 1;
      for (int i = 0; i < int'(order); i++) g = g * longint'(decim);
      return g;
   endfunction

   function automatic longint sat_max(input int unsigned w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int unsigned w);
      return -(longint'(1) <<< (w - 1));
   endfunction

   function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction

endpackage

// File: rtl/pdm_cic_channel.sv
// One PDM channel: input synchroniser, CIC integrators and combs, output
// scaling with saturation, optional DC removal and a magnitude noise gate.
module pdm_cic_channel
   import pdm_pkg::*;
#(
   parameter int unsigned CIC_ORDER = 3,
   parameter int unsigned DECIM     = 64,
   parameter int unsigned OUT_W     = 16,
   parameter int unsigned DC_ALPHA  = 10
) (
   input  logic                    pdm_clk,
   input  logic                    rst,
   input  logic                    pdm,
   input  logic                    strobe,
   input  logic                    accept,
   input  logic                    dc_en,
   input  logic [OUT_W-2:0]        gate_th,
   output logic signed [OUT_W-1:0] sample_c
);

   localparam int unsigned ACC_W = acc_width(CIC_ORDER, DECIM);
   localparam int          SHIFT = int'(ACC_W) - int'(OUT_W);
   localparam int unsigned SHR   = (SHIFT >= 0) ? SHIFT : 0;
   localparam int unsigned SHL   = (SHIFT < 0) ? -SHIFT : 0;
   localparam int unsigned SW    = (ACC_W > OUT_W) ? ACC_W + 1 : OUT_W + 1;
   localparam int unsigned DW    = OUT_W + DC_ALPHA;

   localparam logic [ACC_W:0]          GAIN = (ACC_W+1)'(cic_gain(CIC_ORDER, DECIM));
   localparam logic signed [SW-1:0]    SMAX = SW'(sat_max(OUT_W));
   localparam logic signed [SW-1:0]    SMIN = SW'(sat_min(OUT_W));
   localparam logic signed [OUT_W:0]   YMAX = (OUT_W+1)'(sat_max(OUT_W));
   localparam logic signed [OUT_W:0]   YMIN = (OUT_W+1)'(sat_min(OUT_W));

   logic [1:0]               sync;
   logic [ACC_W-1:0]         integ [CIC_ORDER];
   logic [ACC_W-1:0]         dly   [CIC_ORDER];
   logic [ACC_W-1:0]         stage_in_c [CIC_ORDER];
   logic [ACC_W-1:0]         comb_c;
   logic [ACC_W-1:0]         comb_out;
   logic signed [DW-1:0]     dc_est;

   logic signed [ACC_W:0]    bip_c;
   logic signed [SW-1:0]     wide_c;
   logic signed [SW-1:0]     scaled_c;
   logic signed [OUT_W-1:0]  x_c;
   logic signed [OUT_W-1:0]  dc_c;
   logic signed [OUT_W:0]    diff_c;
   logic signed [DW-1:0]     dc_next_c;
   logic signed [OUT_W-1:0]  y_c;
   logic signed [OUT_W:0]    ye_c;
   logic [OUT_W:0]           mag_c;

   // Comb cascade evaluated on the last integrator, differential delay 1
   always_comb begin
      logic [ACC_W-1:0] acc;
      acc = integ[CIC_ORDER-1];
      for (int k = 0; k < int'(CIC_ORDER); k++) begin
         stage_in_c[k] = acc;
         acc = acc - dly[k];
      end
      comb_c = acc;
   end

   // Integrators accumulate the 0/1 bit; the +1/-1 value is restored below as
   // 2*count - DECIM^ORDER, which keeps +full-scale distinct from -full-scale
   always_ff @(posedge pdm_clk or posedge rst) begin
      if (rst) begin
         sync     <= '0;
         comb_out <= '0;
         dc_est   <= '0;
         for (int k = 0; k < int'(CIC_ORDER); k++) begin
            integ[k] <= '0;
            dly[k]   <= '0;
         end
      end else begin
         sync     <= {sync[0], pdm};
         integ[0] <= integ[0] + ACC_W'(sync[1]);
         for (int k = 1; k < int'(CIC_ORDER); k++) integ[k] <= integ[k] + integ[k-1];
         if (strobe) begin
            for (int k = 0; k < int'(CIC_ORDER); k++) dly[k] <= stage_in_c[k];
            comb_out <= comb_c;
         end
         if (accept && dc_en) dc_est <= dc_next_c;
      end
   end

   always_comb begin
      bip_c    = $signed({comb_out, 1'b0} - GAIN);
      wide_c   = SW'(bip_c);
      scaled_c = (wide_c >>> SHR) <<< SHL;
      if (scaled_c > SMAX)      x_c = OUT_W'(SMAX);
      else if (scaled_c < SMIN) x_c = OUT_W'(SMIN);
      else                      x_c = OUT_W'(scaled_c);

      dc_c      = dc_est[DW-1:DC_ALPHA];
      diff_c    = (OUT_W+1)'(x_c) - (OUT_W+1)'(dc_c);
      dc_next_c = dc_est + DW'(diff_c);
      if (!dc_en)             y_c = x_c;
      else if (diff_c > YMAX) y_c = OUT_W'(YMAX);
      else if (diff_c < YMIN) y_c = OUT_W'(YMIN);
      else                    y_c = OUT_W'(diff_c);

      ye_c     = (OUT_W+1)'(y_c);
      mag_c    = ye_c[OUT_W] ? -ye_c : ye_c;
      sample_c = (mag_c < (OUT_W+1)'(gate_th)) ? '0 : y_c;
   end

endmodule

// File: rtl/pdm_cic_decimator.sv
// Multi-channel PDM to PCM decimator: shared window counter, warm-up discard
// and a single-entry valid/ready output register with sticky overrun.
module pdm_cic_decimator
   import pdm_pkg::*;
#(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned CIC_ORDER = 3,
   parameter int unsigned DECIM     = 64,
   parameter int unsigned OUT_W     = 16,
   parameter int unsigned DC_ALPHA  = 10
) (
   input  logic                      pdm_clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         pdm_in,
   input  logic                      dc_en,
   input  logic [OUT_W-2:0]          gate_th,
   input  logic                      clr_ovr,
   output logic [NUM_CH*OUT_W-1:0]   pcm_data,
   output logic                      pcm_valid,
   input  logic                      pcm_ready,
   output logic                      overrun
);

   localparam int unsigned CNT_W = $clog2(DECIM);
   localparam int unsigned WU_W  = $clog2(CIC_ORDER + 1);

   logic [CNT_W-1:0]          cnt;
   logic                      load;
   logic [WU_W-1:0]           warm;
   logic                      strobe_c;
   logic                      new_c;
   logic                      take_c;
   logic                      drop_c;
   logic [NUM_CH*OUT_W-1:0]   samples_c;

   assign strobe_c = (cnt == CNT_W'(DECIM - 1));
   assign new_c    = load && (warm == WU_W'(CIC_ORDER));
   assign take_c   = new_c && (!pcm_valid || pcm_ready);
   assign drop_c   = new_c && pcm_valid && !pcm_ready;

   for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_ch
      pdm_cic_channel #(
         .CIC_ORDER (CIC_ORDER),
         .DECIM     (DECIM),
         .OUT_W     (OUT_W),
         .DC_ALPHA  (DC_ALPHA)
      ) u_ch (
         .pdm_clk  (pdm_clk),
         .rst      (rst),
         .pdm      (pdm_in[k]),
         .strobe   (strobe_c),
         .accept   (new_c),
         .dc_en    (dc_en),
         .gate_th  (gate_th),
         .sample_c (samples_c[ch_lsb(k, OUT_W) +: OUT_W])
      );
   end

   // Window timing, warm-up discard and output handshake
   always_ff @(posedge pdm_clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         load      <= 1'b0;
         warm      <= '0;
         pcm_data  <= '0;
         pcm_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         cnt  <= strobe_c ? '0 : cnt + CNT_W'(1);
         load <= strobe_c;
         if (load && (warm != WU_W'(CIC_ORDER))) warm <= warm + WU_W'(1);
         if (take_c) begin
            pcm_data  <= samples_c;
            pcm_valid <= 1'b1;
         end else if (pcm_valid && pcm_ready) begin
            pcm_valid <= 1'b0;
         end
         if (drop_c)       overrun <= 1'b1;
         else if (clr_ovr) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Self-checking bench for pdm_cic_decimator: periodic PDM patterns checked
// against steady-state CIC levels, plus handshake, warm-up, DC and gate scenarios.
module tb_pdm_cic_decimator;

   localparam int NUM_CH      = 2;
   localparam int CIC_ORDER   = 3;
   localparam int DECIM       = 64;
   localparam int OUT_W       = 16;
   localparam int DC_ALPHA    = 4;
   localparam int FIRST_VALID = 257;

   logic                      pdm_clk;
   logic                      rst;
   logic [NUM_CH-1:0]         pdm_in;
   logic                      dc_en;
   logic [OUT_W-2:0]          gate_th;
   logic                      clr_ovr;
   logic [NUM_CH*OUT_W-1:0]   pcm_data;
   logic                      pcm_valid;
   logic                      pcm_ready;
   logic                      overrun;

   int          checks;
   int          failures;
   int          cyc;
   int          phase;
   logic [63:0] pat [NUM_CH];
   int          per [NUM_CH];

   pdm_cic_decimator #(
      .NUM_CH    (NUM_CH),
      .CIC_ORDER (CIC_ORDER),
      .DECIM     (DECIM),
      .OUT_W     (OUT_W),
      .DC_ALPHA  (DC_ALPHA)
   ) dut (
      .pdm_clk   (pdm_clk),
      .rst       (rst),
      .pdm_in    (pdm_in),
      .dc_en     (dc_en),
      .gate_th   (gate_th),
      .clr_ovr   (clr_ovr),
      .pcm_data  (pcm_data),
      .pcm_valid (pcm_valid),
      .pcm_ready (pcm_ready),
      .overrun   (overrun)
   );

   initial begin
      pdm_clk = 1'b0;
      forever #5 pdm_clk = ~pdm_clk;
   end

   always @(posedge pdm_clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Periodic pattern generator, one independent period per channel
   initial begin
      phase  = 0;
      pdm_in = '0;
      forever begin
         @(negedge pdm_clk);
         for (int c = 0; c < NUM_CH; c++) pdm_in[c] = pat[c][phase % per[c]];
         phase++;
      end
   end

   // Steady-state level: DECIM^ORDER * mean(+-1) scaled by 2^-(ACC_W-OUT_W) = 32768*mean
   function automatic int level(input logic [63:0] p, input int n);
      int s;
      int e;
      s = 0;
      for (int i = 0; i < n; i++) s += p[i] ? 1 : -1;
      e = (32768 * s) / n;
      if (e > 32767) e = 32767;
      return e;
   endfunction

   function automatic int ch_val(input int k);
      logic signed [OUT_W-1:0] v;
      v = pcm_data[k*OUT_W +: OUT_W];
      return int'(v);
   endfunction

   task automatic do_reset();
      @(negedge pdm_clk);
      rst = 1'b1;
      repeat (2) @(negedge pdm_clk);
      rst = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      for (int i = 0; i < 2000 && cyc < n; i++) @(negedge pdm_clk);
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (pcm_valid) begin
            ok = 1'b1;
            return;
         end
         @(negedge pdm_clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge pdm_clk);
      checks++;
      if (pcm_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid: got %b expected 0", pcm_valid);
      end
      checks++;
      if (pcm_data !== '0) begin
         failures++;
         $display("FAIL reset_data: got %h expected 0", pcm_data);
      end
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL reset_overrun: got %b expected 0", overrun);
      end
      rst = 1'b0;
   endtask

   task automatic run_levels(input string name, input logic [63:0] p0, input int n0,
                             input logic [63:0] p1, input int n1, input int nsamp);
      int exp_v [NUM_CH];
      bit ok;
      pat[0] = p0; per[0] = n0;
      pat[1] = p1; per[1] = n1;
      exp_v[0] = level(p0, n0);
      exp_v[1] = level(p1, n1);
      do_reset();
      for (int s = 0; s < nsamp; s++) begin
         wait_valid(ok);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL %s timeout: no pcm_valid for sample %0d", name, s);
            return;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (ch_val(c) !== exp_v[c]) begin
               failures++;
               $display("FAIL %s ch%0d sample%0d: got %0d expected %0d", name, c, s, ch_val(c), exp_v[c]);
            end
         end
         @(negedge pdm_clk);
      end
   endtask

   task automatic test_levels();
      logic [63:0] ones;
      logic [63:0] zeros;
      logic [63:0] alt;
      ones  = '1;
      zeros = '0;
      alt   = 64'h5555_5555_5555_5555;
      run_levels("all_ones",    ones,  1, ones,  1, 3);
      run_levels("all_zeros",   zeros, 1, zeros, 1, 3);
      run_levels("alternating", alt,   2, alt,   2, 3);
      run_levels("split",       ones,  1, zeros, 1, 3);
   endtask

   task automatic test_random();
      logic [63:0] r0;
      logic [63:0] r1;
      int          n0;
      int          n1;
      for (int it = 0; it < 6; it++) begin
         r0 = {$urandom, $urandom};
         r1 = {$urandom, $urandom};
         n0 = 1 << $urandom_range(0, 6);
         n1 = 1 << $urandom_range(0, 6);
         run_levels("random", r0, n0, r1, n1, 2);
      end
   endtask

   task automatic test_warmup();
      logic [63:0] ones;
      ones = '1;
      pat[0] = ones; per[0] = 1;
      pat[1] = ones; per[1] = 1;
      pcm_ready = 1'b0;
      do_reset();
      wait_cyc(350);
      checks++;
      if (pcm_valid !== 1'b1) begin
         failures++;
         $display("FAIL warmup_pre_valid: got %b expected 1", pcm_valid);
      end
      rst = 1'b1;
      @(negedge pdm_clk);
      checks++;
      if (pcm_valid !== 1'b0 || overrun !== 1'b0 || pcm_data !== '0) begin
         failures++;
         $display("FAIL midwindow_reset: got valid=%b ovr=%b data=%h expected 0/0/0", pcm_valid, overrun, pcm_data);
      end
      rst = 1'b0;
      for (int i = 0; i < 400 && !pcm_valid; i++) @(negedge pdm_clk);
      checks++;
      if (!pcm_valid || cyc !== FIRST_VALID) begin
         failures++;
         $display("FAIL first_valid_cycle: got valid=%b at cycle %0d expected cycle %0d", pcm_valid, cyc, FIRST_VALID);
      end
      checks++;
      if (ch_val(0) !== 32767) begin
         failures++;
         $display("FAIL first_valid_data: got %0d expected 32767", ch_val(0));
      end
      pcm_ready = 1'b1;
      @(negedge pdm_clk);
   endtask

   task automatic test_overrun();
      logic [63:0] ones;
      logic [63:0] zeros;
      logic [NUM_CH*OUT_W-1:0] held;
      logic [NUM_CH*OUT_W-1:0] exp_d;
      ones  = '1;
      zeros = '0;
      pat[0] = ones;  per[0] = 1;
      pat[1] = zeros; per[1] = 1;
      exp_d = {16'sh8000, 16'sh7fff};
      pcm_ready = 1'b0;
      do_reset();
      wait_cyc(FIRST_VALID);
      held = pcm_data;
      checks++;
      if (pcm_valid !== 1'b1 || held !== exp_d) begin
         failures++;
         $display("FAIL hold_first: got valid=%b data=%h expected 1/%h", pcm_valid, held, exp_d);
      end
      wait_cyc(390);
      checks++;
      if (pcm_valid !== 1'b1 || pcm_data !== exp_d) begin
         failures++;
         $display("FAIL hold_stable: got valid=%b data=%h expected 1/%h", pcm_valid, pcm_data, exp_d);
      end
      checks++;
      if (overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_set: got %b expected 1", overrun);
      end
      wait_cyc(448);
      clr_ovr = 1'b1;
      @(negedge pdm_clk);
      clr_ovr = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin
         failures++;
         $display("FAIL set_beats_clear: got %b expected 1", overrun);
      end
      wait_cyc(450);
      clr_ovr = 1'b1;
      @(negedge pdm_clk);
      clr_ovr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL overrun_clear: got %b expected 0", overrun);
      end
      wait_cyc(512);
      pcm_ready = 1'b1;
      @(negedge pdm_clk);
      pcm_ready = 1'b0;
      checks++;
      if (pcm_valid !== 1'b1 || overrun !== 1'b0 || pcm_data !== exp_d) begin
         failures++;
         $display("FAIL same_cycle_handshake: got valid=%b ovr=%b data=%h expected 1/0/%h", pcm_valid, overrun, pcm_data, exp_d);
      end
      wait_cyc(520);
      pcm_ready = 1'b1;
      @(negedge pdm_clk);
      checks++;
      if (pcm_valid !== 1'b0) begin
         failures++;
         $display("FAIL valid_drop_after_handshake: got %b expected 0", pcm_valid);
      end
   endtask

   task automatic run_dc(input string name, input int th, input int nsamp);
      logic [63:0] ones;
      longint est;
      longint dc;
      longint diff;
      longint y;
      int     exp_v;
      int     prev;
      bit     ok;
      bit     hit_zero;
      ones = '1;
      pat[0] = ones; per[0] = 1;
      pat[1] = ones; per[1] = 1;
      dc_en   = 1'b1;
      gate_th = (OUT_W-1)'(th);
      est      = 0;
      prev     = 32767;
      hit_zero = 1'b0;
      do_reset();
      for (int s = 0; s < nsamp; s++) begin
         dc   = est >>> DC_ALPHA;
         diff = 32767 - dc;
         est  = est + diff;
         y    = (diff > 32767) ? 32767 : (diff < -32768) ? -32768 : diff;
         exp_v = ((y < 0 ? -y : y) < th) ? 0 : int'(y);
         wait_valid(ok);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL %s timeout: no pcm_valid for sample %0d", name, s);
            break;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (ch_val(c) !== exp_v) begin
               failures++;
               $display("FAIL %s ch%0d sample%0d: got %0d expected %0d", name, c, s, ch_val(c), exp_v);
            end
         end
         checks++;
         if (ch_val(0) > prev) begin
            failures++;
            $display("FAIL %s monotonic sample%0d: got %0d expected <= %0d", name, s, ch_val(0), prev);
         end
         prev = ch_val(0);
         if (ch_val(0) == 0) hit_zero = 1'b1;
         @(negedge pdm_clk);
         if (hit_zero && exp_v == 0) break;
      end
      if (th > 0) begin
         checks++;
         if (!hit_zero) begin
            failures++;
            $display("FAIL %s reach_zero: got last %0d expected 0", name, prev);
         end
      end
      dc_en   = 1'b0;
      gate_th = '0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst       = 1'b1;
      dc_en     = 1'b0;
      gate_th   = '0;
      clr_ovr   = 1'b0;
      pcm_ready = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
         pat[c] = '1;
         per[c] = 1;
      end
      test_reset();
      test_levels();
      test_random();
      test_warmup();
      test_overrun();
      run_dc("dc_track", 0, 40);
      run_dc("dc_gate", 128, 150);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pdm_cic_decimator.md
PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent PDM channels, legal range 1..4.
REQ-002 SHALL have parameter CIC_ORDER, default 3: CIC integrator/comb stage count, legal range 1..4.
REQ-003 SHALL have parameter DECIM, default 64: PDM bits per PCM sample, legal range 8..256.
REQ-004 SHALL have parameter OUT_W, default 16: signed PCM width.
REQ-005 SHALL have parameter DC_ALPHA, default 10: DC tracker step of 1/2^DC_ALPHA.
REQ-006 SHALL have port pdm_clk, input, 1: the only clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port pdm_in, input, NUM_CH: one PDM bit per channel per cycle.
REQ-009 SHALL have port dc_en, input, 1: enables DC removal.
REQ-010 SHALL have port gate_th, input, OUT_W-1: noise-gate threshold magnitude; 0 disables the gate.
REQ-011 SHALL have port clr_ovr, input, 1: clears the overrun flag.
REQ-012 SHALL have port pcm_data, output, NUM_CH*OUT_W: signed samples; channel k occupies bits [k*OUT_W +: OUT_W].
REQ-013 SHALL have port pcm_valid, output, 1: pcm_data holds an unconsumed sample set.
REQ-014 SHALL have port pcm_ready, input, 1: consumer accepts the sample when pcm_valid and pcm_ready are both high.
REQ-015 SHALL have port overrun, output, 1: sticky flag, set when a sample set is dropped.

Function
REQ-016 SHALL pass each pdm_in bit through a 2-flop synchroniser, then map it to +1 for 1 and -1 for 0.
REQ-017 SHALL define ACC_W = CIC_ORDER*clog2(DECIM)+1 and use it for all CIC state, with two's-complement wrap in the integrators.
REQ-018 SHALL update CIC_ORDER cascaded integrators per channel every cycle.
REQ-019 SHALL count 0..DECIM-1 with a window counter and raise a strobe when the count is DECIM-1.
REQ-020 SHALL, on each strobe, pass the last integrator output through CIC_ORDER comb stages (differential delay 1).
REQ-021 SHALL scale the comb output by an arithmetic shift right of ACC_W-OUT_W, saturating to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-022 SHALL, when dc_en=1, form dc = dc_est>>>DC_ALPHA (dc_est is OUT_W+DC_ALPHA bits per channel), output sat(x-dc), and update dc_est += (x-dc).
REQ-023 SHALL, when dc_en=0, pass x through unchanged and hold dc_est.
REQ-024 SHALL apply the gate after DC removal: if |y| < gate_th, the output is 0.
REQ-025 SHALL assert pcm_valid exactly 2 cycles after the strobe cycle, with all channels updated together.
REQ-026 SHALL discard the first CIC_ORDER sample sets after reset (comb warm-up) without asserting pcm_valid.
REQ-027 SHALL hold pcm_valid and pcm_data stable until the handshake completes.
REQ-028 SHALL, on handshake without a new sample set in the same cycle, deassert pcm_valid the next cycle.
REQ-029 SHALL, when a new sample set arrives while pcm_valid=1 and pcm_ready=0, drop the new set, keep the old data and set overrun.
REQ-030 SHALL, when a new sample set arrives in the same cycle as a handshake, load the new set and keep pcm_valid=1, with no overrun.
REQ-031 SHALL let a set of overrun in the same cycle as clr_ovr win.

Reset
REQ-032 SHALL, while rst=1, clear all synchronisers, integrators, comb delays, dc_est, the window counter and the warm-up counter.
REQ-033 SHALL, while rst=1, drive pcm_data=0, pcm_valid=0 and overrun=0.
REQ-034 SHALL abandon any window in progress on reset mid-window; the first window after reset release starts at count 0.

Structure
REQ-035 SHALL place ACC_W computation, saturation limits and the channel-slice helper in a shared package, pdm_pkg.
REQ-036 SHALL instantiate one per-channel sub-module, pdm_cic_channel (CIC, scaling, DC, gate), NUM_CH times, with shared counter, strobe and handshake logic in the top level.

Verification (DECIM=64, CIC_ORDER=3, OUT_W=16, ACC_W=19, shift 3)
REQ-037 SHALL cover: all-ones input, dc_en=0, gate_th=0 -> after warm-up, every sample is 32767 (saturated from 32768).
REQ-038 SHALL cover: all-zeros input -> every sample is -32768; alternating 1010 -> every sample is 0.
REQ-039 SHALL cover: ch0 all-ones and ch1 all-zeros -> ch0=32767 and ch1=-32768 in the same beat.
REQ-040 SHALL cover: pcm_ready=0 across 2 strobes -> data unchanged, overrun=1; clr_ovr pulse -> overrun=0.
REQ-041 SHALL cover: all-ones input with dc_en=1 -> output decreases monotonically toward 0; with gate_th=128 the output reaches 0 exactly.
REQ-042 SHALL cover: rst pulse at count 30 -> pcm_valid=0, and the first valid sample appears 2 cycles after strobe 4 post-reset, since 3 sets are discarded for warm-up.
